multi_lane_mem_stage: RTL and testbench
=======================================

// Module: multi_lane_mem_stage
// PURPOSE
//  Parametrised N-lane MEM stage plus MEM/WB registers for the dual-issue core, generalising the 2-lane MEM path.
//  Each cycle it picks the taken or not-taken path bundle, forwards store data from WB and runs an internal data memory.
//  It resolves intra-bundle store/load and store/store hazards, then registers per-lane write-back results.
//  Sits between both EX/MEM register sets and the register-file write port; also feeds MEM-stage forwarding.
// PARAMETERS
//  LANES   2    issue lanes; lane 0 is oldest in program order
//  DATA_W  32   datapath width
//  PC_W    10   return-address width
//  DEPTH   1024 data-memory words; power of two; ADDR_W = log2(DEPTH)
// PORTS
//  clk          in  1             clock, rising edge
//  rst          in  1             synchronous reset, active-high
//  path_sel     in  1             1 = taken-path bundle (_t), 0 = not-taken (_n)
//  stall        in  1             hold MEM/WB, suppress memory writes
//  flush        in  1             kill current MEM bundle
//  alu_res_t/_n in  LANES*DATA_W  per-lane ALU result / byte address
//  st_data_t/_n in  LANES*DATA_W  per-lane store data from EX
//  ret_addr_t/_n in LANES*PC_W    per-lane return address
//  rt_t/_n      in  LANES*5       per-lane store source register
//  dest_t/_n    in  LANES*5       per-lane destination register
//  ctrl_t/_n    in  LANES*5       per lane {jal,reg_write,mem_write,mem_to_reg,mem_read}
//  mem_fwd_data out LANES*DATA_W  MEM-stage result (load ? mem : alu), comb.
//  mem_dest     out LANES*5       selected-bundle dest, comb.
//  mem_regwrite out LANES         selected-bundle reg_write gated by flush, comb.
//  wb_data      out LANES*DATA_W  write-back data (jal ? {0,ret_addr} : result)
//  wb_reg       out LANES*5       write-back register
//  wb_regwrite  out LANES         write-back enable
//  conflict_cnt out 16            saturating count of same-word store collisions
// BEHAVIOUR
//  - Lane k occupies bits [k*W +: W] of every packed bus. Word index = alu_res[ADDR_W+1:2]; upper bits ignored (wrap).
//  - Select: all _t inputs when path_sel=1, else all _n inputs. Purely combinational, no latency.
//  - Store-data fwd, lane i: if rt_i != 0 and some lane k has wb_regwrite[k] with wb_reg[k]==rt_i, use wb_data[k].
//    Several matches -> highest k wins. No match -> st_data_i. Every lane uses its own forwarding select.
//  - Memory read is combinational from the array. Writes take effect at the rising edge.
//  - Intra-bundle bypass: load in lane j reads the newest store data from the highest lane i<j with a matching word.
//    Stores in lanes >= j never affect lane j's read.
//  - Store/store same word in one bundle: highest lane wins; conflict_cnt += 1 per cycle with >=1 collision.
//    conflict_cnt saturates at 16'hFFFF.
//  - Priority: rst > flush > stall.
//    rst: MEM/WB regs, wb_* and conflict_cnt -> 0; no memory writes. Memory contents are not reset.
//    flush: no memory writes. MEM/WB loaded with a bubble (reg_write=0, jal=0, data 0). mem_regwrite forced 0.
//    stall: no memory writes. MEM/WB and conflict_cnt hold.
//  - Latency: MEM result or load data appears on wb_data one cycle after the bundle is in MEM.
//  - wb_data is the registered result, muxed with the registered return address when jal is set.
//    The return address is zero-extended from PC_W.
//  - mem_write or mem_read with a lane's mem_to_reg=0 is legal; reg_write of register 0 is passed through unfiltered.
// TESTING
//  1. LANES=2, path_sel=1: lane0 sw 0x1234 @0x40, lane1 lw @0x40 -> next cycle wb_data lane1 = 0x1234.
//  2. Both lanes store to word 0x10 (A, B) -> mem[4]=B, conflict_cnt 0->1; reload both -> B.
//  3. WB lane1 writes r5=0xBEEF, MEM lane0 sw r5 with stale st_data -> memory holds 0xBEEF.
//     Same with both WB lanes writing r5: lane1 value stored.
//  4. path_sel=0 with _t bundle a store to 0x20 -> memory unchanged; _n lane0 add r3=7 -> wb_reg=3, wb_data=7.
//  5. lane0 jal with ret_addr 0x155 -> wb_data lane0 = 0x00000155, wb_regwrite=1.
//     Asserting flush the same cycle -> wb_regwrite=0.
//  6. Store issued with stall=1 then rst=1 -> memory untouched, wb_* = 0.
//     Forcing 65537 collisions -> conflict_cnt = 0xFFFF.

Source files
------------

// File: rtl/multi_lane_mem_stage.sv
// multi_lane_mem_stage: N-lane MEM stage with internal data memory and MEM/WB registers.
// Selects the taken/not-taken bundle, forwards store data from WB, bypasses intra-bundle
// store->load, resolves store/store collisions (highest lane wins) and registers write-back.
// Ports:
//   clk, rst (sync, active-high), path_sel, stall, flush
//   *_t / *_n         : per-lane EX/MEM bundle (alu_res, st_data, ret_addr, rt, dest, ctrl)
//   mem_fwd_data/mem_dest/mem_regwrite : combinational MEM-stage forwarding view
//   wb_data/wb_reg/wb_regwrite         : MEM/WB register-file write port
//   conflict_cnt      : saturating count of cycles with a same-word store collision
module multi_lane_mem_stage #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    path_sel,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [LANES*DATA_W-1:0] alu_res_t,
    input  logic [LANES*DATA_W-1:0] alu_res_n,
    input  logic [LANES*DATA_W-1:0] st_data_t,
    input  logic [LANES*DATA_W-1:0] st_data_n,
    input  logic [LANES*PC_W-1:0]   ret_addr_t,
    input  logic [LANES*PC_W-1:0]   ret_addr_n,
    input  logic [LANES*5-1:0]      rt_t,
    input  logic [LANES*5-1:0]      rt_n,
    input  logic [LANES*5-1:0]      dest_t,
    input  logic [LANES*5-1:0]      dest_n,
    input  logic [LANES*5-1:0]      ctrl_t,
    input  logic [LANES*5-1:0]      ctrl_n,
    output logic [LANES*DATA_W-1:0] mem_fwd_data,
    output logic [LANES*5-1:0]      mem_dest,
    output logic [LANES-1:0]        mem_regwrite,
    output logic [LANES*DATA_W-1:0] wb_data,
    output logic [LANES*5-1:0]      wb_reg,
    output logic [LANES-1:0]        wb_regwrite,
    output logic [15:0]             conflict_cnt
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CW     = 5;

    // Selected bundle
    logic [LANES*DATA_W-1:0] alu_s, st_s;
    logic [LANES*PC_W-1:0]   ret_s;
    logic [LANES*CW-1:0]     rt_s, dest_s, ctrl_s;

    assign alu_s  = path_sel ? alu_res_t  : alu_res_n;
    assign st_s   = path_sel ? st_data_t  : st_data_n;
    assign ret_s  = path_sel ? ret_addr_t : ret_addr_n;
    assign rt_s   = path_sel ? rt_t       : rt_n;
    assign dest_s = path_sel ? dest_t     : dest_n;
    assign ctrl_s = path_sel ? ctrl_t     : ctrl_n;

    // MEM/WB registers
    logic [LANES*DATA_W-1:0] res_q, res_d;
    logic [LANES*PC_W-1:0]   ret_q, ret_d;
    logic [LANES-1:0]        jal_q, jal_d;
    logic [LANES*CW-1:0]     wb_reg_q, wb_reg_d;
    logic [LANES-1:0]        wb_regwrite_q, wb_regwrite_d;
    logic [15:0]             conflict_cnt_q, conflict_cnt_d;

    logic [DATA_W-1:0] mem_q     [DEPTH];
    logic [DATA_W-1:0] wb_data_l [LANES];
    logic [DATA_W-1:0] st_fwd    [LANES];
    logic [DATA_W-1:0] ld_data   [LANES];
    logic [ADDR_W-1:0] word_l    [LANES];
    logic [LANES-1:0]  is_st, is_jal, is_rw, is_m2r;
    logic              collide;
    logic              mem_we_c;
    logic              unused_mem_read;

    // Per-lane control decode; ctrl = {jal, reg_write, mem_write, mem_to_reg, mem_read}
    always_comb begin
        is_st           = '0;
        is_jal          = '0;
        is_rw           = '0;
        is_m2r          = '0;
        unused_mem_read = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            word_l[i]       = alu_s[i*DATA_W + 2 +: ADDR_W];
            is_jal[i]       = ctrl_s[i*CW + 4];
            is_rw[i]        = ctrl_s[i*CW + 3];
            is_st[i]        = ctrl_s[i*CW + 2];
            is_m2r[i]       = ctrl_s[i*CW + 1];
            // Reads are combinational, so mem_read itself has no effect here
            unused_mem_read = unused_mem_read ^ ctrl_s[i*CW];
        end
    end

    // Write-back data: registered result, or zero-extended return address for jal
    always_comb begin
        wb_data = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            wb_data_l[k] = jal_q[k] ? DATA_W'(ret_q[k*PC_W +: PC_W]) : res_q[k*DATA_W +: DATA_W];
            wb_data[k*DATA_W +: DATA_W] = wb_data_l[k];
        end
    end

    // Store-data forwarding from WB; later lanes override earlier matches
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            st_fwd[i] = st_s[i*DATA_W +: DATA_W];
            if (rt_s[i*CW +: CW] != 5'd0) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (wb_regwrite_q[k] && (wb_reg_q[k*CW +: CW] == rt_s[i*CW +: CW])) begin
                        st_fwd[i] = wb_data_l[k];
                    end
                end
            end
        end
    end

    // Load path: array read, overridden by the youngest older-lane store to the same word
    always_comb begin
        mem_fwd_data = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            ld_data[j] = mem_q[word_l[j]];
            for (int unsigned i = 0; i < j; i++) begin
                if (is_st[i] && (word_l[i] == word_l[j])) begin
                    ld_data[j] = st_fwd[i];
                end
            end
            mem_fwd_data[j*DATA_W +: DATA_W] = is_m2r[j] ? ld_data[j] : alu_s[j*DATA_W +: DATA_W];
        end
    end

    // Same-word store collision detect
    always_comb begin
        collide = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned k = i + 1; k < LANES; k++) begin
                if (is_st[i] && is_st[k] && (word_l[i] == word_l[k])) begin
                    collide = 1'b1;
                end
            end
        end
    end

    assign mem_we_c     = !rst && !flush && !stall;
    assign mem_dest     = dest_s;
    assign mem_regwrite = is_rw & {LANES{~flush}};

    // MEM/WB next state: flush inserts a bubble, stall holds
    always_comb begin
        res_d          = res_q;
        ret_d          = ret_q;
        jal_d          = jal_q;
        wb_reg_d       = wb_reg_q;
        wb_regwrite_d  = wb_regwrite_q;
        conflict_cnt_d = conflict_cnt_q;
        if (flush) begin
            res_d         = '0;
            ret_d         = '0;
            jal_d         = '0;
            wb_reg_d      = '0;
            wb_regwrite_d = '0;
        end else if (!stall) begin
            res_d         = mem_fwd_data;
            ret_d         = ret_s;
            jal_d         = is_jal;
            wb_reg_d      = dest_s;
            wb_regwrite_d = is_rw;
            if (collide && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_d = conflict_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q          <= '0;
            ret_q          <= '0;
            jal_q          <= '0;
            wb_reg_q       <= '0;
            wb_regwrite_q  <= '0;
            conflict_cnt_q <= '0;
        end else begin
            res_q          <= res_d;
            ret_q          <= ret_d;
            jal_q          <= jal_d;
            wb_reg_q       <= wb_reg_d;
            wb_regwrite_q  <= wb_regwrite_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Data memory; ascending lane order lets the highest colliding lane win
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (is_st[i]) begin
                    mem_q[word_l[i]] <= st_fwd[i];
                end
            end
        end
    end

    assign wb_reg       = wb_reg_q;
    assign wb_regwrite  = wb_regwrite_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_multi_lane_mem_stage.sv
// Testbench for multi_lane_mem_stage (LANES=2): directed bundles, expected
// write-back state queued per cycle and compared by an independent monitor.
module tb_multi_lane_mem_stage;

    localparam int unsigned LANES  = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 10;
    localparam int unsigned DEPTH  = 1024;

    // ctrl = {jal, reg_write, mem_write, mem_to_reg, mem_read}
    localparam logic [4:0] C_NOP = 5'b00000;
    localparam logic [4:0] C_SW  = 5'b00100;
    localparam logic [4:0] C_LW  = 5'b01011;
    localparam logic [4:0] C_ALU = 5'b01000;
    localparam logic [4:0] C_JAL = 5'b11000;

    logic clk = 1'b0;
    logic rst, path_sel, stall, flush;
    logic [LANES*DATA_W-1:0] alu_res_t, alu_res_n, st_data_t, st_data_n;
    logic [LANES*PC_W-1:0]   ret_addr_t, ret_addr_n;
    logic [LANES*5-1:0]      rt_t, rt_n, dest_t, dest_n, ctrl_t, ctrl_n;
    logic [LANES*DATA_W-1:0] mem_fwd_data, wb_data;
    logic [LANES*5-1:0]      mem_dest, wb_reg;
    logic [LANES-1:0]        mem_regwrite, wb_regwrite;
    logic [15:0]             conflict_cnt;

    multi_lane_mem_stage #(.LANES(LANES), .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .path_sel(path_sel), .stall(stall), .flush(flush),
        .alu_res_t(alu_res_t), .alu_res_n(alu_res_n),
        .st_data_t(st_data_t), .st_data_n(st_data_n),
        .ret_addr_t(ret_addr_t), .ret_addr_n(ret_addr_n),
        .rt_t(rt_t), .rt_n(rt_n), .dest_t(dest_t), .dest_n(dest_n),
        .ctrl_t(ctrl_t), .ctrl_n(ctrl_n),
        .mem_fwd_data(mem_fwd_data), .mem_dest(mem_dest), .mem_regwrite(mem_regwrite),
        .wb_data(wb_data), .wb_reg(wb_reg), .wb_regwrite(wb_regwrite),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0]  we;
        logic [9:0]  rg;
        logic [63:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic ctl(input logic ps, input logic st, input logic fl, input logic r);
        path_sel = ps; stall = st; flush = fl; rst = r;
    endtask

    task automatic clear();
        alu_res_t = '0; alu_res_n = '0; st_data_t = '0; st_data_n = '0;
        ret_addr_t = '0; ret_addr_n = '0; rt_t = '0; rt_n = '0;
        dest_t = '0; dest_n = '0; ctrl_t = '0; ctrl_n = '0;
    endtask

    task automatic lane(input bit t, input int k, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] s, input logic [4:0] rt, input logic [4:0] d,
                        input logic [9:0] ra);
        if (t) begin
            ctrl_t[k*5 +: 5] = c; alu_res_t[k*32 +: 32] = a; st_data_t[k*32 +: 32] = s;
            rt_t[k*5 +: 5] = rt; dest_t[k*5 +: 5] = d; ret_addr_t[k*10 +: 10] = ra;
        end else begin
            ctrl_n[k*5 +: 5] = c; alu_res_n[k*32 +: 32] = a; st_data_n[k*32 +: 32] = s;
            rt_n[k*5 +: 5] = rt; dest_n[k*5 +: 5] = d; ret_addr_n[k*10 +: 10] = ra;
        end
    endtask

    // Queue the write-back state expected after the coming rising edge
    task automatic expect_wb(input logic [1:0] we, input logic [4:0] r0, input logic [4:0] r1,
                             input logic [31:0] d0, input logic [31:0] d1, input logic [15:0] cnt);
        exp_t e;
        e.we = we; e.rg = {r1, r0}; e.data = {d1, d0}; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Monitor: compares outputs after each edge for which an expectation was queued
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("wb_regwrite",  64'(wb_regwrite),  64'(mon_e.we));
            chk("wb_reg",       64'(wb_reg),       64'(mon_e.rg));
            chk("wb_data",      64'(wb_data),      mon_e.data);
            chk("conflict_cnt", 64'(conflict_cnt), 64'(mon_e.cnt));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear();
        ctl(1, 0, 0, 1);
        @(negedge clk);
        // Reset state
        expect_wb(2'b00, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Store 0x1234 @0x40 in lane0, load it back in lane1 via bypass
        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_SW, 32'h40, 32'h1234, 0, 0, 0);
        lane(1, 1, C_LW, 32'h40, 32'h0, 0, 2, 0);
        expect_wb(2'b10, 0, 2, 32'h40, 32'h1234, 0);
        #1 chk("mem_fwd_data_bypass", 64'(mem_fwd_data[63:32]), 64'h1234);
        @(negedge clk);

        // Two stores to word 0x10: lane1 wins, collision counted
        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_SW, 32'h10, 32'hAAAA0001, 0, 0, 0);
        lane(1, 1, C_SW, 32'h10, 32'hBBBB0002, 0, 0, 0);
        expect_wb(2'b00, 0, 0, 32'h10, 32'h10, 1);
        @(negedge clk);

        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_LW, 32'h10, 0, 0, 4, 0);
        lane(1, 1, C_LW, 32'h10, 0, 0, 5, 0);
        expect_wb(2'b11, 4, 5, 32'hBBBB0002, 32'hBBBB0002, 1);
        @(negedge clk);

        // WB lane1 writes r5=0xBEEF
        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_ALU, 32'h3, 0, 0, 7, 0);
        lane(1, 1, C_ALU, 32'hBEEF, 0, 0, 5, 0);
        expect_wb(2'b11, 7, 5, 32'h3, 32'hBEEF, 1);
        @(negedge clk);

        // sw r5 with stale data -> forwarded 0xBEEF stored at 0x80
        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_SW, 32'h80, 32'hDEAD, 5, 0, 0);
        expect_wb(2'b00, 0, 0, 32'h80, 32'h0, 1);
        @(negedge clk);

        // Both WB lanes write r5
        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_ALU, 32'h11111111, 0, 0, 5, 0);
        lane(1, 1, C_ALU, 32'h22222222, 0, 0, 5, 0);
        expect_wb(2'b11, 5, 5, 32'h11111111, 32'h22222222, 1);
        @(negedge clk);

        // sw r5 @0x84 takes lane1 WB value; lane1 load of 0x84 bypasses it
        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_SW, 32'h84, 32'hDEAD, 5, 0, 0);
        lane(1, 1, C_LW, 32'h84, 0, 0, 6, 0);
        expect_wb(2'b10, 0, 6, 32'h84, 32'h22222222, 1);
        @(negedge clk);

        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_LW, 32'h80, 0, 0, 8, 0);
        lane(1, 1, C_LW, 32'h84, 0, 0, 9, 0);
        expect_wb(2'b11, 8, 9, 32'hBEEF, 32'h22222222, 1);
        @(negedge clk);

        // Younger-lane store must not affect older-lane load
        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_LW, 32'h40, 0, 0, 10, 0);
        lane(1, 1, C_SW, 32'h40, 32'h5555, 0, 0, 0);
        expect_wb(2'b01, 10, 0, 32'h1234, 32'h40, 1);
        @(negedge clk);

        // Not-taken path: _t store ignored, _n add r3=7
        clear(); ctl(0, 0, 0, 0);
        lane(1, 0, C_SW, 32'h40, 32'h9999, 0, 0, 0);
        lane(0, 0, C_ALU, 32'h7, 0, 0, 3, 0);
        expect_wb(2'b01, 3, 0, 32'h7, 32'h0, 1);
        @(negedge clk);

        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_LW, 32'h40, 0, 0, 11, 0);
        expect_wb(2'b01, 11, 0, 32'h5555, 32'h0, 1);
        @(negedge clk);

        // jal: return address zero-extended
        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_JAL, 32'h1000, 0, 0, 31, 10'h155);
        expect_wb(2'b01, 31, 0, 32'h155, 32'h0, 1);
        #1 chk("mem_regwrite_jal", 64'(mem_regwrite), 64'h1);
        chk("mem_dest_jal", 64'(mem_dest[4:0]), 64'd31);
        @(negedge clk);

        // Stall: WB holds, store suppressed
        clear(); ctl(1, 1, 0, 0);
        lane(1, 0, C_SW, 32'h40, 32'h6666, 0, 0, 0);
        lane(1, 1, C_ALU, 32'h9, 0, 0, 1, 0);
        expect_wb(2'b01, 31, 0, 32'h155, 32'h0, 1);
        @(negedge clk);

        // Flush with jal: bubble, store suppressed
        clear(); ctl(1, 0, 1, 0);
        lane(1, 0, C_JAL, 32'h1000, 0, 0, 31, 10'h155);
        lane(1, 1, C_SW, 32'h40, 32'h7777, 0, 0, 0);
        expect_wb(2'b00, 0, 0, 32'h0, 32'h0, 1);
        #1 chk("mem_regwrite_flush", 64'(mem_regwrite), 64'h0);
        @(negedge clk);

        // Reset with a store pending: no write, everything cleared
        clear(); ctl(1, 0, 0, 1);
        lane(1, 0, C_SW, 32'h40, 32'h8888, 0, 0, 0);
        expect_wb(2'b00, 0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);

        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_LW, 32'h40, 0, 0, 12, 0);
        lane(1, 1, C_LW, 32'h10, 0, 0, 13, 0);
        expect_wb(2'b11, 12, 13, 32'h5555, 32'hBBBB0002, 0);
        @(negedge clk);

        // 65537 collision cycles saturate the counter
        clear(); ctl(1, 0, 0, 0);
        lane(1, 0, C_SW, 32'h400, 32'h1, 0, 0, 0);
        lane(1, 1, C_SW, 32'h400, 32'h2, 0, 0, 0);
        repeat (65537) @(negedge clk);

        clear(); ctl(1, 0, 0, 0);
        expect_wb(2'b00, 0, 0, 32'h0, 32'h0, 16'hFFFF);
        @(negedge clk);
        @(negedge clk);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
